// File: rtl/id_ex_if.sv
// id_ex_if: decode-to-execute bus for the ID/EX pipeline register.
//   master drives: i_flush, i_id_ctrl, i_id_pc4, i_id_rd1, i_id_rd2, i_id_imm, i_id_rs, i_id_rt, i_id_rd
//   slave drives:  o_ex_ctrl, o_ex_pc4, o_ex_rd1, o_ex_rd2, o_ex_imm, o_ex_rs, o_ex_rt, o_ex_rd,
//                  o_stall (combinational), o_bubble_cnt
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              i_flush;
    logic [8:0]        i_id_ctrl;
    logic [DATA_W-1:0] i_id_pc4, i_id_rd1, i_id_rd2, i_id_imm;
    logic [4:0]        i_id_rs, i_id_rt, i_id_rd;
    logic [8:0]        o_ex_ctrl;
    logic [DATA_W-1:0] o_ex_pc4, o_ex_rd1, o_ex_rd2, o_ex_imm;
    logic [4:0]        o_ex_rs, o_ex_rt, o_ex_rd;
    logic              o_stall;
    logic [CNT_W-1:0]  o_bubble_cnt;
    modport master (
        output i_flush, i_id_ctrl, i_id_pc4, i_id_rd1, i_id_rd2, i_id_imm, i_id_rs, i_id_rt, i_id_rd,
        input  o_ex_ctrl, o_ex_pc4, o_ex_rd1, o_ex_rd2, o_ex_imm, o_ex_rs, o_ex_rt, o_ex_rd,
               o_stall, o_bubble_cnt
    );
    modport slave (
        input  i_flush, i_id_ctrl, i_id_pc4, i_id_rd1, i_id_rd2, i_id_imm, i_id_rs, i_id_rt, i_id_rd,
        output o_ex_ctrl, o_ex_pc4, o_ex_rd1, o_ex_rd2, o_ex_imm, o_ex_rs, o_ex_rt, o_ex_rd,
               o_stall, o_bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion, flush and bubble counter.
//   clk   rising-edge clock
//   reset asynchronous active-high; clears every ex_* field and the bubble counter
//   bus   id_ex_if.slave: decode-side inputs, execute-side latched outputs, stall, bubble_cnt
// Build option: define HAZARD_DETECT_EN to enable load-use detection; otherwise the block is a
// plain register with only flush and reset clears, stall is 0 and bubble_cnt stays 0.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic   clk,
    input  logic   reset,
    id_ex_if.slave bus
);
    logic [8:0]        r_ex_ctrl;
    logic [DATA_W-1:0] r_ex_pc4, r_ex_rd1, r_ex_rd2, r_ex_imm;
    logic [4:0]        r_ex_rs, r_ex_rt, r_ex_rd;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_hazard, w_stall;

`ifdef HAZARD_DETECT_EN
    // a load in EX whose destination is read by the instruction in decode
    assign w_hazard = r_ex_ctrl[5] & (r_ex_rt != 5'd0) &
                      ((r_ex_rt == bus.i_id_rs) | (r_ex_rt == bus.i_id_rt));
`else
    assign w_hazard = 1'b0;
`endif
    // flush discards the decode instruction, so there is nothing to hold
    assign w_stall = w_hazard & ~bus.i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ctrl    <= '0;
            r_ex_pc4     <= '0;
            r_ex_rd1     <= '0;
            r_ex_rd2     <= '0;
            r_ex_imm     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_bubble_cnt <= '0;
        end else begin
            // flush and bubble both zero the control bundle; data fields load regardless
            r_ex_ctrl <= (bus.i_flush | w_hazard) ? 9'd0 : bus.i_id_ctrl;
            r_ex_pc4  <= bus.i_id_pc4;
            r_ex_rd1  <= bus.i_id_rd1;
            r_ex_rd2  <= bus.i_id_rd2;
            r_ex_imm  <= bus.i_id_imm;
            r_ex_rs   <= bus.i_id_rs;
            r_ex_rt   <= bus.i_id_rt;
            r_ex_rd   <= bus.i_id_rd;
            if (w_stall && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.o_ex_ctrl    = r_ex_ctrl;
    assign bus.o_ex_pc4     = r_ex_pc4;
    assign bus.o_ex_rd1     = r_ex_rd1;
    assign bus.o_ex_rd2     = r_ex_rd2;
    assign bus.o_ex_imm     = r_ex_imm;
    assign bus.o_ex_rs      = r_ex_rs;
    assign bus.o_ex_rt      = r_ex_rt;
    assign bus.o_ex_rd      = r_ex_rd;
    assign bus.o_stall      = w_stall;
    assign bus.o_bubble_cnt = r_bubble_cnt;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between instruction decode and execute. Latches the 9-bit control bundle produced by opcode decode, together with PC+4, both register-file read values, the sign-extended immediate and the rs/rt/rd register specifiers. It detects load-use hazards, stalls the front end for one cycle and inserts a bubble. It also clears its contents on a taken-branch flush and counts inserted bubbles for performance monitoring.

## Interface
- DATA_W, 32, width of PC+4, register read data and immediate
- CNT_W, 16, width of the bubble counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  taken branch resolved; discard the instruction currently in decode
- id_ctrl  in  9  control bundle, bit order {reg_dst[8], alu_src[7], branch[6], mem_read[5], mem_write[4], reg_write[3], mem_to_reg[2], alu_op[1:0]}
- id_pc4  in  DATA_W  PC+4 of the decode instruction
- id_rd1, id_rd2  in  DATA_W  register-file read data for rs and rt
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- ex_ctrl  out  9  latched control bundle, same bit order
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DATA_W  latched data
- ex_rs, ex_rt, ex_rd  out  5 each  latched specifiers
- stall  out  1  combinational; when 1, the PC and the IF/ID register must hold
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard condition: hazard = ex_ctrl[5] & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall = hazard & ~flush.
- Register update priority on each rising clk edge:
  - reset, asynchronous: all ex_* outputs and bubble_cnt go to 0.
  - flush: ex_ctrl <= 0. Data and specifier fields are loaded from id_* but are don't-care.
  - hazard and no flush: bubble. ex_ctrl <= 0, bubble_cnt increments. Data fields load from id_* as don't-care.
  - otherwise: all ex_* fields <= corresponding id_* fields.
- A bubble has ex_ctrl == 0, so it has no register write, no memory access and no branch.
- X on don't-care bits of id_ctrl (reg_dst and mem_to_reg for store/branch) passes through unmodified in the normal path. Flush, bubble and reset always produce exact zeros.
- bubble_cnt increments by 1 per inserted bubble and holds at 2^CNT_W−1. Flush-only cycles are not counted.

## Timing
- Latency is one cycle: values presented in cycle N appear on ex_* after the edge ending cycle N.
- stall is combinational from the ex_ctrl, ex_rt, id_rs, id_rt and flush inputs, valid in the same cycle.
- A load-use stall lasts exactly one cycle. After the bubble, ex_ctrl[5] = 0, so hazard deasserts and the held instruction proceeds on the next edge.
- Back-to-back loads where the second depends on the first: one stall, then normal flow.
- flush and hazard in the same cycle: flush wins, stall = 0, and bubble_cnt does not increment.
- reset asserted mid-operation clears state immediately without waiting for clk. stall is 0 while reset is held because ex_ctrl is 0.
- Load to $0 (ex_rt == 0) never stalls.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, stall generation, bubble insertion and bubble_cnt behave as described above.
- HAZARD_DETECT_EN undefined:
  - hazard is tied to 0, so stall is always 0.
  - bubble_cnt stays 0.
  - The block is a plain register with only the flush and reset clears.
  - Software must insert NOPs after loads.

## Test plan
- Reset: assert reset with id_ctrl = 9'h1FF, id_rd1 = 32'hDEADBEEF -> all ex_* = 0, stall = 0, bubble_cnt = 0 immediately, before any clock edge.
- R-type pass-through: id_ctrl = {1,0,0,0,0,1,0,2'b10} = 9'h10A, id_rd1 = 5, id_rd2 = 7, rs = 1, rt = 2, rd = 3 -> next edge ex_ctrl = 9'h10A and all fields match the inputs; stall = 0.
- Load-use: lw with rt = 8 latched (ex_ctrl = 9'h0AC), decode holds add with rs = 8 -> stall = 1 for one cycle; next ex_ctrl = 0; bubble_cnt = 1; following edge latches the add, stall = 0.
- Load to $0: ex_ctrl = 9'h0AC, ex_rt = 0, id_rs = 0 -> stall = 0, no bubble.
- Flush plus hazard: load-use condition with flush = 1 -> stall = 0, ex_ctrl = 0 after the edge, bubble_cnt unchanged.
- Counter saturation: CNT_W = 2, force 4 bubbles -> bubble_cnt reads 1, 2, 3, 3. With HAZARD_DETECT_EN undefined, the load-use stimulus gives stall = 0 and bubble_cnt = 0.
